// File: rtl/regarb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regarb_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREGS    = 32;
  localparam int NREQ_DEF = 4;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Width of a requester index; kept at least 1 bit so NREQ=2 still works.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int PTRW = ptr_width(NREQ_DEF);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from ptr_i upward, modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  int lane;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    lane    = 0;
    for (int k = 0; k < NREQ; k++) begin
      lane = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[lane]) begin
        valid_o     = 1'b1;
        gnt_o[lane] = 1'b1;
        idx_o       = PW'(lane);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the Regs write port, with a post-reset clear sweep of registers 1..NREGS-1.
// Optional macro REGARB_PRIO_EN gives requester 0 fixed top priority over the round-robin lanes.
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = regarb_pkg::AW,
  parameter int DW    = regarb_pkg::DW,
  parameter int NREGS = regarb_pkg::NREGS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               init_done,
  output logic               we,
  output logic [AW-1:0]      reg_Wt_addr,
  output logic [DW-1:0]      wdata
);

  import regarb_pkg::*;

  localparam int PW = ptr_width(NREQ);

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [AW-1:0]   cnt_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            init_done_q;

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic            prio_win;
  logic [NREQ-1:0] run_gnt;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [PW-1:0]   ptr_next;

`ifdef REGARB_PRIO_EN
  // Lane 0 bypasses the rotation entirely; the picker only sees lanes 1..NREQ-1.
  assign pick_req = {req[NREQ-1:1], 1'b0};
  assign prio_win = req[0];
`else
  assign pick_req = req;
  assign prio_win = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    run_gnt   = prio_win ? NREQ'(1) : pick_gnt;
    win_idx   = prio_win ? '0 : pick_idx;
    win_valid = prio_win | pick_valid;
    ptr_next  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Only the winning lane is selected, so X on idle lanes never reaches the outputs.
  assign win_addr = req_addr[int'(win_idx)*AW +: AW];
  assign win_data = req_data[int'(win_idx)*DW +: DW];

  assign gnt         = (state_q == ST_RUN) ? run_gnt : '0;
  assign init_done   = init_done_q;
  assign we          = we_q;
  assign reg_Wt_addr = addr_q;
  assign wdata       = data_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      cnt_q       <= AW'(1);
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          data_q <= '0;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (win_valid) begin
            // Writes to register 0 are consumed but dropped.
            we_q   <= (win_addr != '0);
            addr_q <= win_addr;
            data_q <= win_data;
            if (!prio_win) ptr_q <= ptr_next;
          end else begin
            we_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: scenario tasks plus randomized traffic against a behavioural model.
// Honours REGARB_PRIO_EN in the model when the design is built with it.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int VW   = NREQ + 1 + AW + DW + 1;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               init_done;
  logic               we;
  logic [AW-1:0]      reg_Wt_addr;
  logic [DW-1:0]      wdata;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .gnt         (gnt),
    .init_done   (init_done),
    .we          (we),
    .reg_Wt_addr (reg_Wt_addr),
    .wdata       (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int              m_ptr;
  bit              m_run;
  int              m_cnt;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic            m_done;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] obs_gnt;
  logic [VW-1:0]   obs;
  logic [VW-1:0]   exp_v;

  function automatic void model_reset();
    m_ptr  = 0;
    m_run  = 0;
    m_cnt  = 1;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_done = 1'b0;
  endfunction

  // Returns the winning lane or -1.
  function automatic int pick(input logic [NREQ-1:0] r);
    int lane;
`ifdef REGARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      lane = (m_ptr + k) % NREQ;
`ifdef REGARB_PRIO_EN
      if (lane != 0 && r[lane]) return lane;
`else
      if (r[lane]) return lane;
`endif
    end
    return -1;
  endfunction

  // One clock: drive inputs just after an edge, sample gnt mid-cycle, sample registered outputs 1ns after the next edge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    int w;
    req      = r;
    req_addr = a;
    req_data = d;
    #2;
    obs_gnt = gnt;
    w       = m_run ? pick(r) : -1;
    m_gnt   = (w >= 0) ? NREQ'(1 << w) : '0;
    @(posedge clk);
    if (!m_run) begin
      m_we   = 1'b1;
      m_addr = AW'(m_cnt);
      m_data = '0;
      if (m_cnt == 31) begin
        m_run  = 1;
        m_done = 1'b1;
      end
      m_cnt++;
    end else if (w >= 0) begin
      m_addr = a[w*AW +: AW];
      m_data = d[w*DW +: DW];
      m_we   = (m_addr != '0);
`ifdef REGARB_PRIO_EN
      if (w != 0) m_ptr = (w + 1) % NREQ;
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end else begin
      m_we = 1'b0;
    end
    #1;
    obs   = {obs_gnt, we, reg_Wt_addr, wdata, init_done};
    exp_v = {m_gnt, m_we, m_addr, m_data, m_done};
  endtask

  task automatic make_lanes(input logic [NREQ-1:0] r, output logic [NREQ*AW-1:0] a, output logic [NREQ*DW-1:0] d);
    for (int i = 0; i < NREQ; i++) begin
      a[i*AW +: AW] = r[i] ? AW'($urandom_range(0, 31)) : 'x;
      d[i*DW +: DW] = r[i] ? $urandom : 'x;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    req      = 4'b1111;
    req_addr = '1;
    req_data = '1;
    model_reset();
    #3;
    checks++;
    if ({gnt, we, reg_Wt_addr, wdata, init_done} !== '0) begin
      errors++;
      $display("FAIL reset_initial got %h want 0", {gnt, we, reg_Wt_addr, wdata, init_done});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({gnt, we, reg_Wt_addr, wdata, init_done} !== '0) begin
      errors++;
      $display("FAIL reset_held got %h want 0", {gnt, we, reg_Wt_addr, wdata, init_done});
    end
  endtask

  task automatic test_sweep();
    rst = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cycle(4'b1111, {4{5'd7}}, {4{32'hDEADBEEF}});
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sweep[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    cycle(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11});
    checks++;
    if (obs !== exp_v || obs_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant got %h want %h (gnt %b)", obs, exp_v, obs_gnt);
    end
  endtask

  task automatic test_single();
    cycle(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0});
    checks++;
    if (obs !== exp_v || obs_gnt !== 4'b0100 || we !== 1'b1 || reg_Wt_addr !== 5'd5 || wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL single_write got %h want %h", obs, exp_v);
    end
    cycle(4'b0000, 'x, 'x);
    checks++;
    if (obs !== exp_v || we !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_rotate();
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    make_lanes(4'b1000, a, d);
    cycle(4'b1000, a, d);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rotate_setup got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      make_lanes(4'b1111, a, d);
      cycle(4'b1111, a, d);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rotate[%0d] got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_addr0();
    cycle(4'b0010, {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hAAAA5555, 32'h0});
    checks++;
    if (obs !== exp_v || we !== 1'b0) begin
      errors++;
      $display("FAIL addr0_drop got %h want %h", obs, exp_v);
    end
    cycle(4'b1111, {5'd8, 5'd9, 5'd10, 5'd11}, {32'h8, 32'h9, 32'hA, 32'hB});
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL addr0_next got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_prio();
    logic [NREQ-1:0] want;
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0011, {5'd0, 5'd0, 5'd2, 5'd1}, {32'h0, 32'h0, 32'h2222, 32'h1111});
`ifdef REGARB_PRIO_EN
      want = 4'b0001;
`else
      want = m_gnt;
`endif
      checks++;
      if (obs !== exp_v || obs_gnt !== want) begin
        errors++;
        $display("FAIL prio[%0d] got %h want %h (gnt %b)", i, obs, exp_v, obs_gnt);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0]    r;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    for (int i = 0; i < 300; i++) begin
      r = NREQ'($urandom);
      make_lanes(r, a, d);
      cycle(r, a, d);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] req %b got %h want %h", i, r, obs, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cycle(4'b1111, '0, '0);
    checks++;
    if (obs !== exp_v || reg_Wt_addr !== 5'd12) begin
      errors++;
      $display("FAIL sweep_to_12 got %h want %h", obs, exp_v);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, we, reg_Wt_addr, wdata, init_done} !== '0) begin
      errors++;
      $display("FAIL async_mid_sweep got %h want 0", {gnt, we, reg_Wt_addr, wdata, init_done});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(4'b1111, '0, '0);
    checks++;
    if (obs !== exp_v || reg_Wt_addr !== 5'd1) begin
      errors++;
      $display("FAIL sweep_restart got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 30; i++) cycle(4'b0000, 'x, 'x);
    cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h0, 32'h12345678});
    checks++;
    if (obs !== exp_v || we !== 1'b1) begin
      errors++;
      $display("FAIL run_write got %h want %h", obs, exp_v);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, we, reg_Wt_addr, wdata, init_done} !== '0) begin
      errors++;
      $display("FAIL async_mid_run got %h want 0", {gnt, we, reg_Wt_addr, wdata, init_done});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(4'b1111, '0, '0);
    checks++;
    if (obs !== exp_v || reg_Wt_addr !== 5'd1) begin
      errors++;
      $display("FAIL run_restart got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_rotate();
    test_addr0();
    test_prio();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
